mem_arbiter: RTL and testbench

- Arbitrates the single unified instruction/data memory between two requesters: the multicycle core controller (fetch, load and store accesses) and the external program loader/debug port.
- Serialises accesses with a request/ready handshake and tolerates variable-latency memory through an ack input.
- Prevents loader starvation and converts a hung memory into an error completion.
- Sits between the core's memory address/data mux and the memory macro.

---
 rtl/mem_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the unified instruction/data memory: the core and the program loader
// share one memory port through a registered IDLE/ACCESS/DONE handshake with timeout.
module mem_arbiter #(
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 32,
  parameter int unsigned MAX_WAIT     = 16,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic [DW-1:0] core_rdata,
  output logic          core_ready,
  output logic          core_err,
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  output logic [DW-1:0] ldr_rdata,
  output logic          ldr_ready,
  output logic          ldr_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          busy
);

  localparam int unsigned WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e        state_q, state_d;
  logic          gnt_ldr_q, gnt_ldr_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] core_rdata_q, core_rdata_d;
  logic          core_ready_q, core_ready_d;
  logic          core_err_q, core_err_d;
  logic [DW-1:0] ldr_rdata_q, ldr_rdata_d;
  logic          ldr_ready_q, ldr_ready_d;
  logic          ldr_err_q, ldr_err_d;
  logic          busy_q, busy_d;
  logic          pick_ldr;

  // Loader takes the port when the core is quiet or has used up its run of consecutive grants.
  assign pick_ldr = ldr_req && (!core_req || (starve_q == SW'(STARVE_LIMIT)));

  always_comb begin
    state_d      = state_q;
    gnt_ldr_d    = gnt_ldr_q;
    wait_d       = wait_q;
    starve_d     = starve_q;
    mem_en_d     = mem_en_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    core_rdata_d = core_rdata_q;
    ldr_rdata_d  = ldr_rdata_q;
    core_ready_d = 1'b0;
    core_err_d   = 1'b0;
    ldr_ready_d  = 1'b0;
    ldr_err_d    = 1'b0;

    case (state_q)
      StIdle: begin
        if (core_req || ldr_req) begin
          gnt_ldr_d   = pick_ldr;
          mem_en_d    = 1'b1;
          mem_we_d    = pick_ldr ? ldr_we : core_we;
          mem_addr_d  = pick_ldr ? ldr_addr : core_addr;
          mem_wdata_d = pick_ldr ? ldr_wdata : core_wdata;
          wait_d      = '0;
          if (pick_ldr || !ldr_req) begin
            starve_d = '0;
          end else if (starve_q != SW'(STARVE_LIMIT)) begin
            starve_d = starve_q + 1'b1;
          end
          state_d = StAccess;
        end
      end

      StAccess: begin
        if (mem_ack) begin
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          if (gnt_ldr_q) begin
            ldr_rdata_d = mem_rdata;
            ldr_ready_d = 1'b1;
          end else begin
            core_rdata_d = mem_rdata;
            core_ready_d = 1'b1;
          end
          state_d = StDone;
        end else if (wait_q == WW'(MAX_WAIT - 1)) begin
          // Hung memory: complete the access with an error and zero data.
          mem_en_d = 1'b0;
          if (gnt_ldr_q) begin
            ldr_rdata_d = '0;
            ldr_ready_d = 1'b1;
            ldr_err_d   = 1'b1;
          end else begin
            core_rdata_d = '0;
            core_ready_d = 1'b1;
            core_err_d   = 1'b1;
          end
          state_d = StDone;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      gnt_ldr_q    <= 1'b0;
      wait_q       <= '0;
      starve_q     <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      core_rdata_q <= '0;
      core_ready_q <= 1'b0;
      core_err_q   <= 1'b0;
      ldr_rdata_q  <= '0;
      ldr_ready_q  <= 1'b0;
      ldr_err_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_ldr_q    <= gnt_ldr_d;
      wait_q       <= wait_d;
      starve_q     <= starve_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      core_rdata_q <= core_rdata_d;
      core_ready_q <= core_ready_d;
      core_err_q   <= core_err_d;
      ldr_rdata_q  <= ldr_rdata_d;
      ldr_ready_q  <= ldr_ready_d;
      ldr_err_q    <= ldr_err_d;
      busy_q       <= busy_d;
    end
  end

  assign core_rdata = core_rdata_q;
  assign core_ready = core_ready_q;
  assign core_err   = core_err_q;
  assign ldr_rdata  = ldr_rdata_q;
  assign ldr_ready  = ldr_ready_q;
  assign ldr_err    = ldr_err_q;
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a behavioural memory with programmable ack delay, and a scoreboard of
// expected completions checked whenever either side sees ready.
module tb_mem_arbiter;

  localparam int MaxWait     = 4;
  localparam int StarveLimit = 2;
  localparam int NoAck       = 99;

  typedef struct {
    bit          ldr;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        core_req, core_we, ldr_req, ldr_we;
  logic [31:0] core_addr, core_wdata, ldr_addr, ldr_wdata;
  logic [31:0] core_rdata, ldr_rdata;
  logic        core_ready, core_err, ldr_ready, ldr_err;
  logic        mem_en, mem_we, mem_ack, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int          total = 0;
  int          bad = 0;
  int          ack_delay = 0;
  int          wcnt = 0;
  exp_t        sbq[$];
  exp_t        mon_e;
  logic [31:0] mem_model[logic [31:0]];

  mem_arbiter #(
    .AW          (32),
    .DW          (32),
    .MAX_WAIT    (MaxWait),
    .STARVE_LIMIT(StarveLimit)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .core_req  (core_req),
    .core_we   (core_we),
    .core_addr (core_addr),
    .core_wdata(core_wdata),
    .core_rdata(core_rdata),
    .core_ready(core_ready),
    .core_err  (core_err),
    .ldr_req   (ldr_req),
    .ldr_we    (ldr_we),
    .ldr_addr  (ldr_addr),
    .ldr_wdata (ldr_wdata),
    .ldr_rdata (ldr_rdata),
    .ldr_ready (ldr_ready),
    .ldr_err   (ldr_err),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    return mem_model.exists(a) ? mem_model[a] : (a ^ 32'h5A5A_5A5A);
  endfunction

  // Memory: ack after ack_delay wait cycles; ack/data noise outside an access must be ignored.
  always @(negedge clk) begin
    if (mem_en) begin
      if (wcnt == ack_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = model_rd(mem_addr);
        if (mem_we) mem_model[mem_addr] = mem_wdata;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
      end
      wcnt++;
    end else begin
      mem_ack   = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      wcnt      = 0;
    end
  end

  always @(negedge clk) begin
    if (core_ready || ldr_ready) begin
      check("one_side", {63'd0, core_ready & ldr_ready}, 64'd0);
      if (sbq.size() == 0) begin
        check("spurious", {62'd0, core_ready, ldr_ready}, 64'd0);
      end else begin
        mon_e = sbq.pop_front();
        check("side", {63'd0, ldr_ready}, {63'd0, mon_e.ldr});
        check("rdata", mon_e.ldr ? ldr_rdata : core_rdata, mon_e.rdata);
        check("err", mon_e.ldr ? ldr_err : core_err, mon_e.err);
        check("other_err", mon_e.ldr ? core_err : ldr_err, 0);
      end
    end
  end

  function automatic exp_t mk_exp(input bit ldr, input logic [31:0] addr, input bit err);
    exp_t e;
    e.ldr   = ldr;
    e.err   = err;
    e.rdata = err ? 32'h0 : model_rd(addr);
    return e;
  endfunction

  task automatic do_req(input bit ldr, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input int dly);
    int lat, en_n, hold_bad;
    bit seen, to;
    @(negedge clk);
    ack_delay = dly;
    to = (dly >= MaxWait);
    sbq.push_back(mk_exp(ldr, addr, to));
    if (ldr) begin
      ldr_req = 1'b1; ldr_we = we; ldr_addr = addr; ldr_wdata = wdata;
    end else begin
      core_req = 1'b1; core_we = we; core_addr = addr; core_wdata = wdata;
    end
    lat = 0; en_n = 0; hold_bad = 0; seen = 0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (mem_en) begin
        en_n++;
        if (mem_we !== we || mem_addr !== addr || (we && mem_wdata !== wdata)) hold_bad++;
      end
      if (ldr ? ldr_ready : core_ready) seen = 1;
    end
    check("seen", {63'd0, seen}, 64'd1);
    check("lat", lat, to ? MaxWait + 1 : dly + 2);
    check("en_cycles", en_n, to ? MaxWait : dly + 1);
    check("hold", hold_bad, 0);
    if (ldr) ldr_req = 1'b0;
    else core_req = 1'b0;
    @(negedge clk);
    check("idle", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int  n;
    bit  ldone;
    rst = 1'b0;
    core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0;
    ldr_req = 0; ldr_we = 0; ldr_addr = 0; ldr_wdata = 0;
    mem_ack = 0; mem_rdata = 0;
    mem_model[32'h40] = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    check("rst_ctl", {57'd0, mem_en, mem_we, busy, core_ready, core_err, ldr_ready, ldr_err}, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_rdata", {core_rdata, ldr_rdata}, 0);
    rst = 1'b1;

    // Single-cycle core read, then a loader write acked in its 4th access cycle.
    do_req(0, 0, 32'h40, 32'h0, 0);
    do_req(1, 1, 32'h100, 32'h1234_5678, 3);

    // Both requesters held: core, core, loader, repeated.
    @(negedge clk);
    ack_delay = 0;
    sbq.push_back(mk_exp(0, 32'h500, 0));
    sbq.push_back(mk_exp(0, 32'h500, 0));
    sbq.push_back(mk_exp(1, 32'h600, 0));
    sbq.push_back(mk_exp(0, 32'h500, 0));
    sbq.push_back(mk_exp(0, 32'h500, 0));
    sbq.push_back(mk_exp(1, 32'h600, 0));
    core_req = 1; core_we = 0; core_addr = 32'h500;
    ldr_req = 1; ldr_we = 0; ldr_addr = 32'h600;
    n = 0;
    for (int i = 0; i < 100 && n < 6; i++) begin
      @(negedge clk);
      if (core_ready || ldr_ready) n++;
    end
    core_req = 0; ldr_req = 0;
    check("starve_n", n, 6);
    @(negedge clk);
    check("idle", {63'd0, busy}, 64'd0);

    // Hung memory, then read back the loader's write.
    do_req(0, 0, 32'h80, 32'h0, NoAck);
    do_req(0, 0, 32'h100, 32'h0, 1);

    // Reset in the second access cycle aborts without a ready pulse.
    @(negedge clk);
    ack_delay = NoAck;
    core_req = 1; core_we = 0; core_addr = 32'h44;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_en", {63'd0, mem_en}, 0);
    check("abort_busy", {63'd0, busy}, 0);
    check("abort_rdata", core_rdata, 0);
    core_req = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    do_req(0, 0, 32'h44, 32'h0, 0);

    // Core-only traffic must leave the loader's credit clear.
    for (int k = 0; k < 10; k++) do_req(0, k[0], 32'h200 + 32'(k * 4), 32'(k), k % 3);

    @(negedge clk);
    ack_delay = 0;
    sbq.push_back(mk_exp(0, 32'h700, 0));
    sbq.push_back(mk_exp(1, 32'h704, 0));
    core_req = 1; core_we = 0; core_addr = 32'h700;
    ldr_req = 1; ldr_we = 0; ldr_addr = 32'h704;
    ldone = 0;
    for (int i = 0; i < 50 && !ldone; i++) begin
      @(negedge clk);
      if (core_ready) core_req = 0;
      if (ldr_ready) begin
        ldr_req = 0;
        ldone = 1;
      end
    end
    core_req = 0; ldr_req = 0;
    check("sim_done", {63'd0, ldone}, 64'd1);
    repeat (2) @(negedge clk);
    check("sb_left", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
